e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit, running beside the ALU in the E stage of the pipelined MIPS core. It takes the same forwarded operands as the ALU and holds the architectural HI/LO registers. Multiply and divide run as multi-cycle operations, and the unit reports busy state so the hazard unit can stall later HI/LO instructions. mfhi/mflo read results through the E-stage result mux.

## Interface
Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (and madd family); must be ≥1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- E_data1  in  32  rs operand, forwarded.
- E_data2  in  32  rt operand, forwarded.
- E_mdu_op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13–15 behave as NOP.
- E_req  in  1  the E-stage instruction is being cancelled (exception/interrupt flush); suppresses every HI/LO side effect this cycle.
- E_start  out  1  combinational; high when a MULT/DIV-class op launches this cycle.
- E_busy  out  1  registered; high while an operation is in flight.
- E_mdu_out  out  32  HI for MFHI, LO for MFLO, otherwise 0.

## Operation
- State:
  - HI, LO: 32 bits each.
  - cnt: 4 bits, sized to max(MUL_CYCLES, DIV_CYCLES).
  - Pending result registers: hi_p, lo_p.
- Reset: HI, LO, cnt, hi_p and lo_p all clear to 0. E_busy=0, E_start=0, E_mdu_out=0.
- E_start = (op ∈ {1..4, 9..12}) && !E_req && cnt==0.
- Launch edge (E_start=1):
  - The full result is computed from E_data1/E_data2 into hi_p/lo_p.
  - cnt loads MUL_CYCLES or DIV_CYCLES.
- Busy phase: cnt decrements each edge while nonzero. On the edge where cnt goes 1→0, hi_p/lo_p copy into HI/LO.
- E_busy = (cnt != 0).
- MULT/MULTU: 64-bit signed/unsigned product; HI = [63:32], LO = [31:0].
- DIV/DIVU:
  - LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0: the op still launches and is busy for DIV_CYCLES, but HI/LO are left unchanged at commit.
- MTHI/MTLO: write E_data1 to HI/LO on the edge, only if !E_req && cnt==0.
- Hazard unit contract: it stalls any nonzero E_mdu_op whenever E_start||E_busy. An op is also ignored by this block if it arrives while cnt!=0.
- MFHI/MFLO: combinational read of the committed HI/LO. E_req has no effect on the read.
- E_req=1: no launch and no HI/LO write. An operation already in flight is not cancelled.
- Reset while busy: the operation is abandoned, cnt=0, HI=LO=0.

## Timing
- Launch at edge t0 → E_busy=1 for cycles t0+1 … t0+N, with N = MUL_CYCLES or DIV_CYCLES.
- New HI/LO are visible from the cycle in which E_busy falls.
- An MFHI issued back-to-back after a MULT enters E at t0+N+1 at the earliest (stall-limited). It reads the new value.
- MTHI/MTLO take effect one edge later. An MFHI in the next cycle reads the written value.
- E_start is never high while E_busy=1.
- When E_req and reset are both high, reset dominates.

## Configuration
- MDU_MADD_EN defined: ops 9–12 are legal.
  - MADD/MADDU: {HI,LO} += signed/unsigned product.
  - MSUB/MSUBU: {HI,LO} −= product.
  - Arithmetic is mod 2^64, using HI/LO as committed at launch. Busy for MUL_CYCLES.
- MDU_MADD_EN undefined: ops 9–12 decode as NOP. E_start=0 for them and no state changes; no accumulate datapath is synthesised.

## Test plan
- MULT 0xFFFFFFFF × 0x00000001, then MFHI/MFLO after busy drops → HI=0xFFFFFFFF, LO=0xFFFFFFFF. E_busy high exactly 5 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. HI still reads the old value on the last busy cycle.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. DIVU 7/0 with HI=0x11, LO=0x22 → unchanged.
- MULT with E_req=1 → E_start=0, E_busy stays 0, HI/LO unchanged. MTLO 0x1234 with E_req=1 → LO unchanged.
- Launch DIV, assert reset at busy cycle 4 → next cycle E_busy=0, HI=LO=0, and no late commit.
- With MDU_MADD_EN: HI:LO=0:0xFFFFFFFF, MADDU 1×1 → HI=1, LO=0. Without MDU_MADD_EN the same op leaves HI:LO unchanged and E_busy=0.

Source files
------------

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit holding architectural HI/LO; multi-cycle ops commit on the last busy edge.
// Optional MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (9-12).
module e_mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_data1,
  input  logic [31:0] E_data2,
  input  logic [3:0]  E_mdu_op,
  input  logic        E_req,
  output logic        E_start,
  output logic        E_busy,
  output logic [31:0] E_mdu_out
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [31:0]      hi_q, hi_d, lo_q, lo_d, hi_p_q, hi_p_d, lo_p_q, lo_p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_mul, is_div, is_acc, is_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] div_a, div_b, uq, ur, quo, rem;

  // Signed operands are sign-extended so a single 64-bit modular multiply serves both flavours.
  always_comb begin
    is_mul    = (E_mdu_op == OP_MULT) || (E_mdu_op == OP_MULTU);
    is_div    = (E_mdu_op == OP_DIV)  || (E_mdu_op == OP_DIVU);
    is_signed = (E_mdu_op == OP_MULT) || (E_mdu_op == OP_DIV);
    is_acc    = 1'b0;
`ifdef MDU_MADD_EN
    is_acc    = (E_mdu_op >= OP_MADD) && (E_mdu_op <= OP_MSUBU);
    is_signed = is_signed || (E_mdu_op == OP_MADD) || (E_mdu_op == OP_MSUB);
`endif
    mul_a = is_signed ? {{32{E_data1[31]}}, E_data1} : {32'd0, E_data1};
    mul_b = is_signed ? {{32{E_data2[31]}}, E_data2} : {32'd0, E_data2};
    prod  = mul_a * mul_b;
  end

  // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner entirely.
  always_comb begin
    div_a = (is_signed && E_data1[31]) ? (32'd0 - E_data1) : E_data1;
    div_b = (is_signed && E_data2[31]) ? (32'd0 - E_data2) : E_data2;
    if (div_b == 32'd0) div_b = 32'd1;
    uq  = div_a / div_b;
    ur  = div_a % div_b;
    quo = (is_signed && (E_data1[31] ^ E_data2[31])) ? (32'd0 - uq) : uq;
    rem = (is_signed && E_data1[31]) ? (32'd0 - ur) : ur;
  end

  assign E_start = (is_mul || is_div || is_acc) && !E_req && (cnt_q == '0);
  assign E_busy  = (cnt_q != '0);

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_p_d = hi_p_q;
    lo_p_d = lo_p_q;
    cnt_d  = cnt_q;
    if (E_start) begin
      cnt_d = is_div ? DIV_CNT : MUL_CNT;
      if (is_div) begin
        hi_p_d = (E_data2 == 32'd0) ? hi_q : rem;
        lo_p_d = (E_data2 == 32'd0) ? lo_q : quo;
      end else begin
        {hi_p_d, lo_p_d} = prod;
`ifdef MDU_MADD_EN
        if (E_mdu_op == OP_MADD || E_mdu_op == OP_MADDU)
          {hi_p_d, lo_p_d} = {hi_q, lo_q} + prod;
        else if (E_mdu_op == OP_MSUB || E_mdu_op == OP_MSUBU)
          {hi_p_d, lo_p_d} = {hi_q, lo_q} - prod;
`endif
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        hi_d = hi_p_q;
        lo_d = lo_p_q;
      end
    end else if (!E_req) begin
      if (E_mdu_op == OP_MTHI) hi_d = E_data1;
      if (E_mdu_op == OP_MTLO) lo_d = E_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      hi_p_q <= '0;
      lo_p_q <= '0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_p_q <= hi_p_d;
      lo_p_q <= lo_p_d;
      cnt_q  <= cnt_d;
    end
  end

  assign E_mdu_out = (E_mdu_op == OP_MFHI) ? hi_q :
                     (E_mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: multiply/divide results, busy timing, cancel, reset-while-busy, accumulate ops.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] E_data1 = '0;
  logic [31:0] E_data2 = '0;
  logic [3:0]  E_mdu_op = '0;
  logic        E_req = 1'b0;
  logic        E_start, E_busy;
  logic [31:0] E_mdu_out;

  int tests = 0;
  int fails = 0;

`ifdef MDU_MADD_EN
  localparam logic        MADD_START = 1'b1;
  localparam int          MADD_N     = 5;
  localparam logic [31:0] MADD_HI    = 32'h1;
  localparam logic [31:0] MADD_LO    = 32'h0;
`else
  localparam logic        MADD_START = 1'b0;
  localparam int          MADD_N     = 0;
  localparam logic [31:0] MADD_HI    = 32'h0;
  localparam logic [31:0] MADD_LO    = 32'hFFFF_FFFF;
`endif

  e_mdu dut (
    .clk(clk), .reset(reset), .E_data1(E_data1), .E_data2(E_data2),
    .E_mdu_op(E_mdu_op), .E_req(E_req), .E_start(E_start), .E_busy(E_busy),
    .E_mdu_out(E_mdu_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    @(negedge clk);
    E_mdu_op = op; E_data1 = a; E_data2 = b; E_req = req;
    #1;
  endtask

  // Issues MFHI each cycle, counting busy cycles; last_hi is HI on the final busy cycle, fin_hi when busy falls.
  task automatic run_busy(output int n, output logic [31:0] last_hi, output logic [31:0] fin_hi);
    bit done = 1'b0;
    n = 0; last_hi = '0; fin_hi = '0;
    for (int i = 0; i < 30 && !done; i++) begin
      drive(4'd7, 32'd0, 32'd0, 1'b0);
      if (E_busy) begin n++; last_hi = E_mdu_out; end
      else begin done = 1'b1; fin_hi = E_mdu_out; end
    end
  endtask

  task automatic test_reset;
    drive(4'd7, 32'd0, 32'd0, 1'b0);
    tests++; if (E_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", E_busy); end
    tests++; if (E_mdu_out !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h want 0", E_mdu_out); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h want 0", E_mdu_out); end
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    tests++; if (E_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %0b want 0", E_start); end
    reset = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_mult;
    int n; logic [31:0] l, h;
    drive(4'd1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    tests++; if (E_start !== 1'b1) begin fails++; $display("FAIL mult_start: got %0b want 1", E_start); end
    run_busy(n, l, h);
    tests++; if (n != 5) begin fails++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    tests++; if (h !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h want ffffffff", h); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_lo: got %h want ffffffff", E_mdu_out); end
    $display("[TB] test_mult done");
  endtask

  task automatic test_multu;
    int n; logic [31:0] l, h;
    drive(4'd5, 32'h0000_AAAA, 32'd0, 1'b0);
    drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tests++; if (E_start !== 1'b1) begin fails++; $display("FAIL multu_start: got %0b want 1", E_start); end
    run_busy(n, l, h);
    tests++; if (n != 5) begin fails++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    tests++; if (l !== 32'h0000_AAAA) begin fails++; $display("FAIL multu_old_hi_last_busy: got %h want 0000aaaa", l); end
    tests++; if (h !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi: got %h want fffffffe", h); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'h1) begin fails++; $display("FAIL multu_lo: got %h want 00000001", E_mdu_out); end
    $display("[TB] test_multu done");
  endtask

  task automatic test_div;
    int n; logic [31:0] l, h;
    drive(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b0);
    run_busy(n, l, h);
    tests++; if (n != 10) begin fails++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    tests++; if (h !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi: got %h want ffffffff", h); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo: got %h want fffffffd", E_mdu_out); end
    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_busy(n, l, h);
    tests++; if (h !== 32'h0) begin fails++; $display("FAIL div_ovf_hi: got %h want 0", h); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo: got %h want 80000000", E_mdu_out); end
    $display("[TB] test_div done");
  endtask

  task automatic test_divu_zero;
    int n; logic [31:0] l, h;
    drive(4'd5, 32'h11, 32'd0, 1'b0);
    drive(4'd6, 32'h22, 32'd0, 1'b0);
    drive(4'd4, 32'h7, 32'h0, 1'b0);
    tests++; if (E_start !== 1'b1) begin fails++; $display("FAIL divz_start: got %0b want 1", E_start); end
    run_busy(n, l, h);
    tests++; if (n != 10) begin fails++; $display("FAIL divz_busy_cycles: got %0d want 10", n); end
    tests++; if (h !== 32'h11) begin fails++; $display("FAIL divz_hi: got %h want 00000011", h); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'h22) begin fails++; $display("FAIL divz_lo: got %h want 00000022", E_mdu_out); end
    $display("[TB] test_divu_zero done");
  endtask

  task automatic test_req;
    drive(4'd1, 32'h5, 32'h6, 1'b1);
    tests++; if (E_start !== 1'b0) begin fails++; $display("FAIL req_start: got %0b want 0", E_start); end
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    tests++; if (E_busy !== 1'b0) begin fails++; $display("FAIL req_busy: got %0b want 0", E_busy); end
    drive(4'd6, 32'h1234, 32'd0, 1'b1);
    drive(4'd7, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'h11) begin fails++; $display("FAIL req_hi: got %h want 00000011", E_mdu_out); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'h22) begin fails++; $display("FAIL req_lo: got %h want 00000022", E_mdu_out); end
    $display("[TB] test_req done");
  endtask

  task automatic test_back_to_back;
    drive(4'd5, 32'hCAFE, 32'd0, 1'b0);
    drive(4'd7, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'hCAFE) begin fails++; $display("FAIL mthi_mfhi: got %h want 0000cafe", E_mdu_out); end
    drive(4'd6, 32'hBEEF, 32'd0, 1'b0);
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'hBEEF) begin fails++; $display("FAIL mtlo_mflo: got %h want 0000beef", E_mdu_out); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_busy;
    drive(4'd5, 32'h55, 32'd0, 1'b0);
    drive(4'd6, 32'h66, 32'd0, 1'b0);
    drive(4'd3, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'd0, 32'd0, 32'd0, 1'b0);
    tests++; if (E_busy !== 1'b1) begin fails++; $display("FAIL rb_busy_c4: got %0b want 1", E_busy); end
    reset = 1'b1;
    drive(4'd7, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    tests++; if (E_busy !== 1'b0) begin fails++; $display("FAIL rb_busy_after: got %0b want 0", E_busy); end
    tests++; if (E_mdu_out !== 32'd0) begin fails++; $display("FAIL rb_hi: got %h want 0", E_mdu_out); end
    for (int i = 0; i < 12; i++) drive(4'd0, 32'd0, 32'd0, 1'b0);
    drive(4'd7, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'd0) begin fails++; $display("FAIL rb_late_hi: got %h want 0", E_mdu_out); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== 32'd0) begin fails++; $display("FAIL rb_late_lo: got %h want 0", E_mdu_out); end
    $display("[TB] test_reset_busy done");
  endtask

  task automatic test_madd;
    int n; logic [31:0] l, h;
    drive(4'd5, 32'h0, 32'd0, 1'b0);
    drive(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    drive(4'd10, 32'h1, 32'h1, 1'b0);
    tests++; if (E_start !== MADD_START) begin fails++; $display("FAIL maddu_start: got %0b want %0b", E_start, MADD_START); end
    run_busy(n, l, h);
    tests++; if (n != MADD_N) begin fails++; $display("FAIL maddu_busy_cycles: got %0d want %0d", n, MADD_N); end
    tests++; if (h !== MADD_HI) begin fails++; $display("FAIL maddu_hi: got %h want %h", h, MADD_HI); end
    drive(4'd8, 32'd0, 32'd0, 1'b0);
    tests++; if (E_mdu_out !== MADD_LO) begin fails++; $display("FAIL maddu_lo: got %h want %h", E_mdu_out, MADD_LO); end
    $display("[TB] test_madd done");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_req();
    test_back_to_back();
    test_reset_busy();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
